// File: rtl/div_fixed_point.sv
// Iterative signed (sign-magnitude) fixed-point divider using restoring long division.
// One quotient bit per clock; saturates on overflow and on divide-by-zero.
module div_fixed_point #(
  parameter int unsigned SIZE_DIV_FIXED = 32,
  parameter int unsigned INT_PART       = 15
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      valid_in,
  input  logic [SIZE_DIV_FIXED-1:0] A,
  input  logic [SIZE_DIV_FIXED-1:0] B,
  output logic                      ready_in,
  output logic                      valid_out,
  output logic [SIZE_DIV_FIXED-1:0] OUT,
  output logic                      overflow,
  output logic                      div_by_zero
);

  localparam int unsigned W     = SIZE_DIV_FIXED;
  localparam int unsigned MAG_W = W - 1;
  localparam int unsigned FRAC  = W - 1 - INT_PART;
  localparam int unsigned ITER  = W - 1 + FRAC;
  localparam int unsigned RW    = W + 1;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t            state_q, state_d;
  logic [ITER-1:0]   dvd_q, dvd_d;
  logic [MAG_W-1:0]  bmag_q, bmag_d;
  logic              sign_q, sign_d;
  logic [W-1:0]      rem_q, rem_d;
  logic [ITER-2:0]   quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [W-1:0]      out_q, out_d;
  logic              ovf_q, ovf_d;
  logic              dbz_q, dbz_d;

  logic [RW-1:0]     rem_sh;
  logic              ge;
  logic [W-1:0]      rem_nx;
  logic [ITER-1:0]   quo_nx;
  logic              ovf_c;
  logic              dbz_c;
  logic [MAG_W-1:0]  res_mag;
  logic              res_sign;

  // Next-state, restoring step and result formatting
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    bmag_d  = bmag_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    out_d   = out_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    rem_sh   = {rem_q, dvd_q[ITER-1]};
    ge       = (rem_sh >= RW'(bmag_q));
    rem_nx   = ge ? W'(rem_sh - RW'(bmag_q)) : W'(rem_sh);
    quo_nx   = {quo_q, ge};
    ovf_c    = |quo_nx[ITER-1:MAG_W];
    dbz_c    = (bmag_q == '0);
    res_mag  = (ovf_c || dbz_c) ? {MAG_W{1'b1}} : quo_nx[MAG_W-1:0];
    // Never emit negative zero
    res_sign = sign_q & (|res_mag);

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d = CALC;
          dvd_d   = {A[MAG_W-1:0], {FRAC{1'b0}}};
          bmag_d  = B[MAG_W-1:0];
          sign_d  = A[W-1] ^ B[W-1];
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      CALC: begin
        dvd_d = {dvd_q[ITER-2:0], 1'b0};
        rem_d = rem_nx;
        quo_d = quo_nx[ITER-2:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
          valid_d = 1'b1;
          out_d   = {res_sign, res_mag};
          ovf_d   = ovf_c & ~dbz_c;
          dbz_d   = dbz_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      bmag_q  <= '0;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      bmag_q  <= bmag_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready_in    = ready_q;
  assign valid_out   = valid_q;
  assign OUT         = out_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/div_fixed_point.md
# div_fixed_point

Iterative signed fixed-point divider, the inverse counterpart of the pipelined fixed-point multiplier in the DQN datapath. Computes OUT = A / B on sign-magnitude operands using restoring long division, one quotient bit per clock. Used for normalisation and learning-rate scaling, where throughput needs are low and area matters more than latency. Results saturate on overflow and on divide-by-zero, and each case is flagged.

## Interface
- SIZE_DIV_FIXED, 32, total word width: bit [SIZE-1] is the sign, the rest is magnitude.
- INT_PART, 15, integer magnitude bits. FRAC = SIZE_DIV_FIXED-1-INT_PART, which is 16 at the defaults. The constraint INT_PART < SIZE_DIV_FIXED-1 holds.
- clk  in  1  system clock, all logic on the rising edge.
- rstn  in  1  reset, synchronous and active-low.
- valid_in  in  1  operands valid. Accepted only when ready_in=1.
- A  in  SIZE_DIV_FIXED  dividend, sign-magnitude fixed point.
- B  in  SIZE_DIV_FIXED  divisor, sign-magnitude fixed point.
- ready_in  out  1  block idle and able to accept an operation.
- valid_out  out  1  one-cycle pulse, result valid.
- OUT  out  SIZE_DIV_FIXED  quotient, sign-magnitude, same format as the inputs.
- overflow  out  1  quotient magnitude saturated. Qualified by valid_out.
- div_by_zero  out  1  |B| was 0. Qualified by valid_out.

## Operation
- FSM states: IDLE and CALC.
- IDLE: ready_in=1. When valid_in=1 at an edge:
  - register |A|, |B| and the result sign A[MSB]^B[MSB];
  - clear the remainder and the quotient; set the bit counter to 0;
  - go to CALC.
- The input operands may change freely after acceptance.
- CALC: ready_in=0. Each edge performs one restoring step on the 47-bit (SIZE-1+FRAC) dividend |A|<<FRAC, MSB first:
  - rem = {rem, next dividend bit};
  - if rem ≥ |B|: subtract |B| and shift in a 1, else shift in a 0.
  - The remainder register is SIZE bits wide.
- ITER = SIZE_DIV_FIXED-1+FRAC = 47 steps. On the edge that completes step ITER, register OUT, the flags and valid_out=1, and return to IDLE.
- Result rules:
  - Quotient is truncated toward zero. No rounding.
  - If any quotient bit above bit SIZE-2 is 1: magnitude = all ones (0x7FFFFFFF at the defaults) and overflow=1.
  - If |B|=0: magnitude = all ones, div_by_zero=1, overflow=0. The sign is still A^B sign. The iterations still run, so latency is uniform.
  - If the result magnitude is 0: the sign bit is forced to 0. The block never outputs negative zero.
  - Negative-zero inputs are treated as zero.
- valid_in while ready_in=0 is ignored. It is not queued.

## Timing
- Reset (rstn=0 at an edge) forces:
  - state=IDLE;
  - OUT=0, valid_out=0, overflow=0, div_by_zero=0;
  - ready_in=1 in the following cycle.
- Reset mid-CALC aborts the operation. No valid_out is produced for it.
- Latency: operation accepted at edge k → valid_out high during the cycle after edge k+47. That is 47 cycles.
- ready_in is low from after edge k through edge k+47. It returns to 1 in the same cycle that valid_out is 1.
- A new op can therefore be accepted at edge k+48. Maximum throughput is one op per 48 cycles.
- valid_out is high for exactly 1 cycle.
- OUT and the flags hold their values until the next completion or reset.

## Test plan
- Basic: A=0x00020000 (2.0), B=0x00008000 (0.5) → OUT=0x00040000, flags 0, valid_out exactly 47 cycles after acceptance.
- Sign and fraction:
  - A=0x80030000 (-3.0), B=0x00020000 → OUT=0x80018000 (-1.5).
  - A=0x00010000, B=0x00030000 → OUT=0x00005555 (truncated).
  - A=0x80000001, B=0x00020000 → OUT=0x00000000 (zero forced positive).
- Overflow and divide-by-zero:
  - A=0x7FFF0000, B=0x00000001 → OUT=0x7FFFFFFF, overflow=1.
  - A=0x80010000, B=0 → OUT=0xFFFFFFFF, div_by_zero=1, overflow=0.
- Handshake: hold valid_in=1 with 40 random operand pairs:
  - operations are accepted only at ready_in=1, spaced 48 cycles apart;
  - operands driven while busy are dropped;
  - every result matches a reference model computed from the accepted operands only.
- Reset mid-operation: assert rstn=0 for 1 cycle at step 20 of CALC:
  - no valid_out appears;
  - all outputs read 0 and ready_in=1 the cycle after reset is released;
  - the next operation (6.0/3.0 → 0x00020000) completes correctly.
